// File: rtl/tx_arb_pkg.sv
// Shared state encoding, sizes and exponent helper for tx_slice_arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_TX_BUSY  = 2'd1,
    ARB_WAIT_ACK = 2'd2,
    ARB_POST     = 2'd3
  } arb_state_t;

  localparam int         NUM_SLICE    = 4;
  localparam logic [3:0] CW_SHIFT_MAX = 4'd15;

  // min(cw_min + shift, cw_max), with an inverted min/max pair collapsing to cw_max
  function automatic logic [3:0] cw_exp_sat(input logic [3:0] min_exp,
                                            input logic [3:0] max_exp,
                                            input logic [3:0] shift);
    logic [4:0] sum;
    sum = {1'b0, min_exp} + {1'b0, shift};
    if (min_exp > max_exp) return max_exp;
    if (sum > {1'b0, max_exp}) return max_exp;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way request picker: round-robin from ptr, or a descending search
// when TX_ARB_STRICT_PRIORITY_EN is defined (the top then ties ptr to 3).
module rr_pick4
  import tx_arb_pkg::*;
(
  input  logic [NUM_SLICE-1:0] req,
  input  logic [1:0]           ptr,
  output logic                 grant_valid,
  output logic [1:0]           grant_idx
);

  always_comb begin
    logic [1:0] cand;
    grant_valid = |req;
    grant_idx   = ptr;
    cand        = ptr;
    // walk from the farthest candidate back so the nearest one to ptr wins
    for (int i = NUM_SLICE - 1; i >= 0; i--) begin
`ifdef TX_ARB_STRICT_PRIORITY_EN
      cand = ptr - 2'(i);
`else
      cand = ptr + 2'(i);
`endif
      if (req[cand]) grant_idx = cand;
    end
  end

endmodule

// File: rtl/tx_slice_arbiter.sv
// Grants the CSMA/CA transmit opportunity to one of four queues and runs the
// TX / ACK-wait / post sequence. Optional macro: TX_ARB_STRICT_PRIORITY_EN.
module tx_slice_arbiter
  import tx_arb_pkg::*;
#(
  parameter int RETRY_W  = 4,
  parameter int ACK_TO_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tsf_pulse_1M,
  input  logic [3:0]          high_tx_allowed,
  input  logic [3:0]          queue_nonempty,
  input  logic [3:0]          ack_required,
  input  logic                tx_done,
  input  logic                ack_ok,
  input  logic [3:0]          cw_min_exp,
  input  logic [3:0]          cw_max_exp,
  input  logic [RETRY_W-1:0]  retry_limit,
  input  logic [ACK_TO_W-1:0] ack_timeout_us,
  output logic                tx_start,
  output logic [1:0]          tx_queue_idx,
  output logic [3:0]          tx_cw_exp,
  output logic [3:0]          queue_pop,
  output logic                tx_drop,
  output logic [RETRY_W-1:0]  tx_retry_cnt,
  output logic                arb_busy
);

  arb_state_t          state_q, state_nxt;
  logic [1:0]          idx_nxt;
  logic                start_nxt, drop_nxt;
  logic [3:0]          pop_nxt;
  logic                ack_req_q, ack_req_nxt;
  logic [ACK_TO_W-1:0] timer_q, timer_nxt;
  logic [RETRY_W-1:0]  retry_q   [NUM_SLICE];
  logic [RETRY_W-1:0]  retry_nxt [NUM_SLICE];
  logic [3:0]          shift_q   [NUM_SLICE];
  logic [3:0]          shift_nxt [NUM_SLICE];
  logic [RETRY_W:0]    lim_eff;
  logic                grant_valid;
  logic [1:0]          grant_idx;
  logic [1:0]          pick_ptr;
  logic                succ, fail;

`ifdef TX_ARB_STRICT_PRIORITY_EN
  assign pick_ptr = 2'd3;
`else
  logic [1:0] rr_ptr_q, rr_ptr_nxt;
  assign pick_ptr = rr_ptr_q;
`endif

  rr_pick4 u_pick (
    .req         (queue_nonempty & high_tx_allowed),
    .ptr         (pick_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // a retry limit of zero still allows one attempt
  assign lim_eff      = (retry_limit == '0) ? (RETRY_W+1)'(1) : {1'b0, retry_limit};
  assign tx_retry_cnt = retry_q[tx_queue_idx];
  assign tx_cw_exp    = cw_exp_sat(cw_min_exp, cw_max_exp, shift_q[tx_queue_idx]);
  assign arb_busy     = (state_q != ARB_IDLE);

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = tx_queue_idx;
    start_nxt   = 1'b0;
    pop_nxt     = '0;
    drop_nxt    = 1'b0;
    ack_req_nxt = ack_req_q;
    timer_nxt   = timer_q;
    retry_nxt   = retry_q;
    shift_nxt   = shift_q;
    succ        = 1'b0;
    fail        = 1'b0;
`ifndef TX_ARB_STRICT_PRIORITY_EN
    rr_ptr_nxt  = rr_ptr_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          idx_nxt     = grant_idx;
          start_nxt   = 1'b1;
          ack_req_nxt = ack_required[grant_idx];
          state_nxt   = ARB_TX_BUSY;
`ifndef TX_ARB_STRICT_PRIORITY_EN
          rr_ptr_nxt  = grant_idx + 2'd1;
`endif
        end
      end
      ARB_TX_BUSY: begin
        if (tx_done) begin
          if (ack_req_q) begin
            timer_nxt = '0;
            state_nxt = ARB_WAIT_ACK;
          end else begin
            succ      = 1'b1;
            state_nxt = ARB_POST;
          end
        end
      end
      ARB_WAIT_ACK: begin
        // ack_ok beats a timeout landing in the same cycle
        if (ack_ok) begin
          succ      = 1'b1;
          state_nxt = ARB_POST;
        end else if (timer_q >= ack_timeout_us) begin
          fail      = 1'b1;
          state_nxt = ARB_POST;
        end else if (tsf_pulse_1M) begin
          timer_nxt = timer_q + 1'b1;
        end
      end
      ARB_POST: begin
        if (high_tx_allowed == '0) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase

    if (succ) begin
      pop_nxt                 = 4'b0001 << tx_queue_idx;
      retry_nxt[tx_queue_idx] = '0;
      shift_nxt[tx_queue_idx] = '0;
    end else if (fail) begin
      if (({1'b0, retry_q[tx_queue_idx]} + 1'b1) >= lim_eff) begin
        pop_nxt                 = 4'b0001 << tx_queue_idx;
        drop_nxt                = 1'b1;
        retry_nxt[tx_queue_idx] = '0;
        shift_nxt[tx_queue_idx] = '0;
      end else begin
        retry_nxt[tx_queue_idx] = retry_q[tx_queue_idx] + 1'b1;
        if (shift_q[tx_queue_idx] != CW_SHIFT_MAX)
          shift_nxt[tx_queue_idx] = shift_q[tx_queue_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ARB_IDLE;
      tx_queue_idx <= '0;
      tx_start     <= 1'b0;
      queue_pop    <= '0;
      tx_drop      <= 1'b0;
      ack_req_q    <= 1'b0;
      timer_q      <= '0;
      for (int i = 0; i < NUM_SLICE; i++) begin
        retry_q[i] <= '0;
        shift_q[i] <= '0;
      end
`ifndef TX_ARB_STRICT_PRIORITY_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      tx_queue_idx <= idx_nxt;
      tx_start     <= start_nxt;
      queue_pop    <= pop_nxt;
      tx_drop      <= drop_nxt;
      ack_req_q    <= ack_req_nxt;
      timer_q      <= timer_nxt;
      retry_q      <= retry_nxt;
      shift_q      <= shift_nxt;
`ifndef TX_ARB_STRICT_PRIORITY_EN
      rr_ptr_q     <= rr_ptr_nxt;
`endif
    end
  end

endmodule
